reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised next-generation core register file: DW-bit data, 2**PW entries, NRD combinational read ports and one clocked write port.
- Adds asynchronous clear, same-cycle write-to-read bypass, optional hardwired zero register, and a per-register scoreboard.
- The scoreboard tracks registers reserved by long-latency ops (e.g. loads) and raises a stall when a consumer reads a pending register.
- Sits between decode (read addresses, reservations) and writeback (write port) in the single-cycle/pipelined datapath.

Parameters:
- DW, 8, data width in bits
- PW, 3, address width; depth = 2**PW
- NRD, 2, number of read ports (>=1)
- BYPASS, 1, 1 = a read of the address being written this cycle returns dat_in; 0 = returns the stored value
- ZERO_REG, 0, 1 = entry 0 always reads 0; writes and reservations to it are ignored

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  write enable
- wr_addr  input  PW  write address
- dat_in  input  DW  write data
- rd_addr  input  NRD x PW  read addresses, one per port
- rd_use  input  NRD  port i operand actually consumed this cycle
- dat_out  output  NRD x DW  read data, combinational
- rd_pend  output  NRD  addressed register is pending (after bypass rule)
- stall  output  1  OR over i of (rd_use[i] & rd_pend[i])
- resv_en  input  1  reserve resv_addr for a future write
- resv_addr  input  PW  register to reserve
- resv_busy  output  1  resv_addr is already pending (combinational)

Behaviour:
- Reset: rst_n low clears all entries and all pending bits to 0 immediately, without waiting for clk. dat_out = 0, rd_pend = 0, stall = 0, resv_busy = 0 while held. Reset mid-operation discards in-flight reservations.
- Write: on posedge with wr_en, core[wr_addr] <= dat_in and pend[wr_addr] <= 0. Write latency is 1 cycle: visible at dat_out the cycle after, or the same cycle via bypass.
- Read, combinational: dat_out[i] = core[rd_addr[i]].
  - BYPASS=1 and wr_en and rd_addr[i]==wr_addr: dat_out[i] = dat_in and rd_pend[i] = 0.
  - Multiple ports may read the same address; each gets the identical value.
- Reservation: on posedge with resv_en, pend[resv_addr] <= 1.
  - Reserving an already-pending register is legal: pend stays 1 and resv_busy flags it. No counting; one write clears it.
- Simultaneous wr_en and resv_en on the same address: the write updates data and the reservation wins, so pend = 1 next cycle (new long op issued after the old one completes).
- Simultaneous wr_en and resv_en on different addresses: both take effect independently.
- rd_pend[i] = pend[rd_addr[i]], then the bypass override above. stall is purely combinational; the block itself never holds state on stall.
- ZERO_REG=1: reads of address 0 return 0 and rd_pend = 0. wr_en and resv_en to address 0 are no-ops, and bypass from address 0 yields 0.
- Width rules: no arithmetic. Addresses are fully decoded (all 2**PW entries valid), so there is no out-of-range case.

Optional Feature:
- REG_FILE_TRACE_EN defined: simulation-only $display on every committed write (address, data), every reservation, and every cycle stall is high (port index, address). Must not affect synthesised logic.
- Undefined: no display statements compiled; functionally identical.

Decomposition:
- Package reg_file_pkg holds default constants DW_DEF=8, PW_DEF=3, NRD_DEF=2, and typedefs data_t (logic [DW_DEF-1:0]) and addr_t (logic [PW_DEF-1:0]).
- One sub-module, reg_file_scoreboard: pending-bit vector, reservation and clear logic, rd_pend, resv_busy and stall generation.
- The data array, bypass and zero-register logic stay in reg_file_sb.

Test Plan:
- Async reset: drive garbage writes, pulse rst_n low mid-cycle -> all dat_out = 0 and stall = 0 immediately, before the next clk edge.
- Write/read with bypass: wr_en=1, wr_addr=3, dat_in=8'hA5, rd_addr[0]=3 -> dat_out[0]=8'hA5 same cycle with BYPASS=1. With BYPASS=0 it shows the old value, then 8'hA5 next cycle.
- Scoreboard stall: resv_en at addr 5, next cycle rd_addr[1]=5 with rd_use[1]=1 -> rd_pend[1]=1, stall=1. Then write addr 5 = 8'h3C -> same cycle stall=0 (bypass), 8'h3C returned, pend cleared.
- Simultaneous wr_en+resv_en on addr 2 -> core[2] updated, pend[2]=1 next cycle, resv_busy=1 when resv_addr=2.
- ZERO_REG=1: write 8'hFF to addr 0 and reserve addr 0 -> dat_out for addr 0 stays 0, rd_pend=0, stall never asserts.
- Parameter sweep DW=16, PW=4, NRD=3: write 16 distinct values, read all three ports at different addresses -> each returns its stored value.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the reg_file_sb register file and its scoreboard.
package reg_file_pkg;

    localparam int DW_DEF  = 8;
    localparam int PW_DEF  = 3;
    localparam int NRD_DEF = 2;

    typedef logic [DW_DEF-1:0] data_t;
    typedef logic [PW_DEF-1:0] addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending bits: set by reservations, cleared by writes; drives rd_pend, stall, resv_busy.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int NRD = NRD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [PW-1:0]           wr_addr,
    input  logic                    resv_en,
    input  logic [PW-1:0]           resv_addr,
    input  logic [NRD-1:0][PW-1:0]  rd_addr,
    input  logic [NRD-1:0]          rd_use,
    input  logic [NRD-1:0]          byp_hit,
    output logic [NRD-1:0]          rd_pend,
    output logic                    stall,
    output logic                    resv_busy
);

    localparam int DEPTH = 2**PW;

    logic [DEPTH-1:0] pend_reg;
    logic [DEPTH-1:0] pend_next;

    // Reservation is applied after the clear so a same-address write+reserve leaves the bit set.
    always_comb begin
        pend_next = pend_reg;
        if (wr_en) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (resv_en) begin
            pend_next[resv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            assign rd_pend[gi] = pend_reg[rd_addr[gi]] & ~byp_hit[gi];
        end
    endgenerate

    assign stall     = |(rd_use & rd_pend);
    assign resv_busy = pend_reg[resv_addr];

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass, optional zero register and load scoreboard.
// Define REG_FILE_TRACE_EN for simulation trace of writes, reservations and stalls.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int PW       = PW_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [PW-1:0]           wr_addr,
    input  logic [DW-1:0]           dat_in,
    input  logic [NRD-1:0][PW-1:0]  rd_addr,
    input  logic [NRD-1:0]          rd_use,
    output logic [NRD-1:0][DW-1:0]  dat_out,
    output logic [NRD-1:0]          rd_pend,
    output logic                    stall,
    input  logic                    resv_en,
    input  logic [PW-1:0]           resv_addr,
    output logic                    resv_busy
);

    localparam int DEPTH = 2**PW;

    logic [DW-1:0]  core_reg [DEPTH];
    logic           wr_ok;
    logic           resv_ok;
    logic [NRD-1:0] byp_hit;

    // Entry 0 swallows writes and reservations when it is the hardwired zero.
    assign wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                core_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            core_reg[wr_addr] <= dat_in;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic is_zero;
            assign is_zero     = (ZERO_REG != 0) && (rd_addr[gi] == '0);
            assign byp_hit[gi] = (BYPASS != 0) && wr_en && (rd_addr[gi] == wr_addr);
            // Reset gating keeps the bypass path from leaking dat_in while rst_n is held.
            assign dat_out[gi] = (!rst_n || is_zero) ? '0 :
                                 byp_hit[gi]         ? dat_in :
                                                       core_reg[rd_addr[gi]];
        end
    endgenerate

    reg_file_scoreboard #(
        .PW  (PW),
        .NRD (NRD)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_ok),
        .wr_addr   (wr_addr),
        .resv_en   (resv_ok),
        .resv_addr (resv_addr),
        .rd_addr   (rd_addr),
        .rd_use    (rd_use),
        .byp_hit   (byp_hit),
        .rd_pend   (rd_pend),
        .stall     (stall),
        .resv_busy (resv_busy)
    );

`ifdef REG_FILE_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_ok) begin
                $display("reg_file_sb: write addr %0d data %h", wr_addr, dat_in);
            end
            if (resv_ok) begin
                $display("reg_file_sb: reserve addr %0d", resv_addr);
            end
            for (int i = 0; i < NRD; i++) begin
                if (rd_use[i] && rd_pend[i]) begin
                    $display("reg_file_sb: stall port %0d addr %0d", i, rd_addr[i]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default, no-bypass, zero-register and wide (16/4/3) builds.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n;

    logic             wr_en, resv_en;
    logic [2:0]       wr_addr, resv_addr;
    logic [7:0]       dat_in;
    logic [1:0][2:0]  rd_addr;
    logic [1:0]       rd_use;

    logic [1:0][7:0]  do_a, do_n, do_z;
    logic [1:0]       rp_a, rp_n, rp_z;
    logic             st_a, st_n, st_z;
    logic             rb_a, rb_n, rb_z;

    logic             w_wr_en, w_resv_en;
    logic [3:0]       w_wr_addr, w_resv_addr;
    logic [15:0]      w_dat_in;
    logic [2:0][3:0]  w_rd_addr;
    logic [2:0]       w_rd_use;
    logic [2:0][15:0] w_do;
    logic [2:0]       w_rp;
    logic             w_st, w_rb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addr(rd_addr), .rd_use(rd_use), .dat_out(do_a), .rd_pend(rp_a), .stall(st_a),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_busy(rb_a));

    reg_file_sb #(.BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addr(rd_addr), .rd_use(rd_use), .dat_out(do_n), .rd_pend(rp_n), .stall(st_n),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_busy(rb_n));

    reg_file_sb #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addr(rd_addr), .rd_use(rd_use), .dat_out(do_z), .rd_pend(rp_z), .stall(st_z),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_busy(rb_z));

    reg_file_sb #(.DW(16), .PW(4), .NRD(3), .BYPASS(1), .ZERO_REG(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .dat_in(w_dat_in),
        .rd_addr(w_rd_addr), .rd_use(w_rd_use), .dat_out(w_do), .rd_pend(w_rp), .stall(w_st),
        .resv_en(w_resv_en), .resv_addr(w_resv_addr), .resv_busy(w_rb));

    function automatic logic [15:0] wval(input int i);
        return 16'hC000 | (16'(i) * 16'h0101);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("test_reset");
        checks++; if (do_a !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h expected 0000", do_a); end
        checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", st_a); end
        wr_en = 1; wr_addr = 3'd1; dat_in = 8'h5A; resv_en = 1; resv_addr = 3'd1;
        tick();
        wr_en = 0; resv_en = 0; rd_addr[0] = 3'd1; rd_use = 2'b01;
        #1;
        checks++; if (do_a[0] !== 8'h5A) begin errors++; $display("FAIL pre_reset_data got %h expected 5a", do_a[0]); end
        checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b expected 1", st_a); end
        rst_n = 0;
        #1;
        checks++; if (do_a[0] !== 8'h00) begin errors++; $display("FAIL async_reset_data got %h expected 00", do_a[0]); end
        checks++; if (do_n[0] !== 8'h00) begin errors++; $display("FAIL async_reset_data_nb got %h expected 00", do_n[0]); end
        checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL async_reset_stall got %b expected 0", st_a); end
        checks++; if (rp_a !== 2'b00) begin errors++; $display("FAIL async_reset_pend got %b expected 00", rp_a); end
        checks++; if (rb_a !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b expected 0", rb_a); end
        tick();
        rst_n = 1; rd_use = 2'b00;
    endtask

    task automatic test_bypass();
        $display("test_bypass");
        wr_en = 1; wr_addr = 3'd3; dat_in = 8'hA5; rd_addr[0] = 3'd3; rd_addr[1] = 3'd3;
        #1;
        checks++; if (do_a[0] !== 8'hA5) begin errors++; $display("FAIL bypass_p0 got %h expected a5", do_a[0]); end
        checks++; if (do_a[1] !== 8'hA5) begin errors++; $display("FAIL bypass_p1 got %h expected a5", do_a[1]); end
        checks++; if (do_n[0] !== 8'h00) begin errors++; $display("FAIL nobypass_old got %h expected 00", do_n[0]); end
        tick();
        wr_en = 0;
        #1;
        checks++; if (do_n[0] !== 8'hA5) begin errors++; $display("FAIL nobypass_new got %h expected a5", do_n[0]); end
        checks++; if (do_a[1] !== 8'hA5) begin errors++; $display("FAIL stored_p1 got %h expected a5", do_a[1]); end
    endtask

    task automatic test_stall();
        $display("test_stall");
        rd_addr[1] = 3'd5; rd_use = 2'b10; resv_en = 1; resv_addr = 3'd5;
        #1;
        checks++; if (rp_a[1] !== 1'b0) begin errors++; $display("FAIL pend_before_edge got %b expected 0", rp_a[1]); end
        checks++; if (rb_a !== 1'b0) begin errors++; $display("FAIL busy_before_edge got %b expected 0", rb_a); end
        tick();
        resv_en = 0;
        #1;
        checks++; if (rp_a[1] !== 1'b1) begin errors++; $display("FAIL pend_set got %b expected 1", rp_a[1]); end
        checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL stall_set got %b expected 1", st_a); end
        checks++; if (rb_a !== 1'b1) begin errors++; $display("FAIL busy_set got %b expected 1", rb_a); end
        checks++; if (st_n !== 1'b1) begin errors++; $display("FAIL stall_set_nb got %b expected 1", st_n); end
        rd_use = 2'b00;
        #1;
        checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL stall_unused got %b expected 0", st_a); end
        rd_use = 2'b10; wr_en = 1; wr_addr = 3'd5; dat_in = 8'h3C;
        #1;
        checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL stall_bypass got %b expected 0", st_a); end
        checks++; if (do_a[1] !== 8'h3C) begin errors++; $display("FAIL data_bypass got %h expected 3c", do_a[1]); end
        checks++; if (rp_a[1] !== 1'b0) begin errors++; $display("FAIL pend_bypass got %b expected 0", rp_a[1]); end
        checks++; if (st_n !== 1'b1) begin errors++; $display("FAIL stall_nobypass got %b expected 1", st_n); end
        checks++; if (do_n[1] !== 8'h00) begin errors++; $display("FAIL data_nobypass got %h expected 00", do_n[1]); end
        tick();
        wr_en = 0;
        #1;
        checks++; if (rp_a[1] !== 1'b0) begin errors++; $display("FAIL pend_cleared got %b expected 0", rp_a[1]); end
        checks++; if (st_n !== 1'b0) begin errors++; $display("FAIL stall_cleared_nb got %b expected 0", st_n); end
        checks++; if (do_n[1] !== 8'h3C) begin errors++; $display("FAIL data_written_nb got %h expected 3c", do_n[1]); end
        rd_use = 2'b00;
    endtask

    task automatic test_simul();
        $display("test_simul");
        rd_addr[0] = 3'd2; rd_use = 2'b01;
        wr_en = 1; wr_addr = 3'd2; dat_in = 8'h77; resv_en = 1; resv_addr = 3'd2;
        tick();
        wr_en = 0; resv_en = 0;
        #1;
        checks++; if (do_a[0] !== 8'h77) begin errors++; $display("FAIL same_addr_data got %h expected 77", do_a[0]); end
        checks++; if (rp_a[0] !== 1'b1) begin errors++; $display("FAIL same_addr_pend got %b expected 1", rp_a[0]); end
        checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL same_addr_stall got %b expected 1", st_a); end
        checks++; if (rb_a !== 1'b1) begin errors++; $display("FAIL same_addr_busy got %b expected 1", rb_a); end
        wr_en = 1; wr_addr = 3'd2; dat_in = 8'h11; resv_en = 1; resv_addr = 3'd6;
        tick();
        wr_en = 0; resv_en = 0;
        #1;
        checks++; if (do_a[0] !== 8'h11) begin errors++; $display("FAIL diff_addr_data got %h expected 11", do_a[0]); end
        checks++; if (rp_a[0] !== 1'b0) begin errors++; $display("FAIL diff_addr_pend got %b expected 0", rp_a[0]); end
        checks++; if (rb_a !== 1'b1) begin errors++; $display("FAIL diff_addr_busy got %b expected 1", rb_a); end
        rd_use = 2'b00;
    endtask

    task automatic test_zero_reg();
        $display("test_zero_reg");
        rd_addr[0] = 3'd0; rd_addr[1] = 3'd0; rd_use = 2'b11;
        wr_en = 1; wr_addr = 3'd0; dat_in = 8'hFF; resv_en = 1; resv_addr = 3'd0;
        #1;
        checks++; if (do_z[0] !== 8'h00) begin errors++; $display("FAIL zero_bypass got %h expected 00", do_z[0]); end
        checks++; if (do_a[0] !== 8'hFF) begin errors++; $display("FAIL nonzero_bypass got %h expected ff", do_a[0]); end
        tick();
        wr_en = 0; resv_en = 0;
        #1;
        checks++; if (do_z !== 16'h0000) begin errors++; $display("FAIL zero_data got %h expected 0000", do_z); end
        checks++; if (rp_z !== 2'b00) begin errors++; $display("FAIL zero_pend got %b expected 00", rp_z); end
        checks++; if (st_z !== 1'b0) begin errors++; $display("FAIL zero_stall got %b expected 0", st_z); end
        checks++; if (rb_z !== 1'b0) begin errors++; $display("FAIL zero_busy got %b expected 0", rb_z); end
        checks++; if (do_a[0] !== 8'hFF) begin errors++; $display("FAIL nonzero_entry0 got %h expected ff", do_a[0]); end
        checks++; if (rp_a[0] !== 1'b1) begin errors++; $display("FAIL nonzero_pend0 got %b expected 1", rp_a[0]); end
        rd_use = 2'b00; rd_addr[1] = 3'd4;
        wr_en = 1; wr_addr = 3'd4; dat_in = 8'h42;
        tick();
        wr_en = 0;
        #1;
        checks++; if (do_z[1] !== 8'h42) begin errors++; $display("FAIL zero_other_entry got %h expected 42", do_z[1]); end
    endtask

    task automatic test_sweep();
        $display("test_sweep");
        for (int i = 0; i < 16; i++) begin
            w_wr_en = 1; w_wr_addr = 4'(i); w_dat_in = wval(i);
            tick();
        end
        w_wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            w_rd_addr[0] = 4'(i);
            w_rd_addr[1] = 4'(i + 5);
            w_rd_addr[2] = 4'(i + 11);
            #1;
            checks++; if (w_do[0] !== wval(i)) begin errors++; $display("FAIL sweep_p0 addr %0d got %h expected %h", i, w_do[0], wval(i)); end
            checks++; if (w_do[1] !== wval((i + 5) % 16)) begin errors++; $display("FAIL sweep_p1 addr %0d got %h expected %h", (i + 5) % 16, w_do[1], wval((i + 5) % 16)); end
            checks++; if (w_do[2] !== wval((i + 11) % 16)) begin errors++; $display("FAIL sweep_p2 addr %0d got %h expected %h", (i + 11) % 16, w_do[2], wval((i + 11) % 16)); end
            #1;
        end
    endtask

    initial begin
        rst_n = 0;
        wr_en = 0; wr_addr = '0; dat_in = '0; resv_en = 0; resv_addr = '0;
        rd_addr = '0; rd_use = '0;
        w_wr_en = 0; w_wr_addr = '0; w_dat_in = '0; w_resv_en = 0; w_resv_addr = '0;
        w_rd_addr = '0; w_rd_use = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        test_reset();
        test_bypass();
        test_stall();
        test_simul();
        test_zero_reg();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
